// File: rtl/centipede_pkg.sv
// Shared types and defaults for the Centipede trackball reader.
package centipede_pkg;

    localparam int TB_CNT_W        = 4;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        P1_HOR = 2'd0,
        P1_VER = 2'd1,
        P2_HOR = 2'd2,
        P2_VER = 2'd3
    } tb_sel_t;

    typedef struct packed {
        logic                dir;
        logic [TB_CNT_W-1:0] cnt;
    } tb_axis_t;

    function automatic logic rise(input logic prev, input logic now);
        return now & ~prev;
    endfunction

endpackage

// File: rtl/tb_axis_counter.sv
// One trackball axis: synchronisers, rising-edge detect, wrapping up/down
// counter and direction latch.
module tb_axis_counter
    import centipede_pkg::*;
#(
    parameter int CNT_W       = TB_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             tb_clk,
    input  logic             tb_dir,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             dir
);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dir_sync_q, dir_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dir_q, dir_d;
    logic [CNT_W-1:0]       base_s;
    logic                   event_s;

    // Next-state: clear is applied first so a coincident event is never lost.
    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], tb_clk};
        dir_sync_d = {dir_sync_q[SYNC_STAGES-2:0], tb_dir};
        clk_prev_d = clk_sync_q[SYNC_STAGES-1];
        event_s    = rise(clk_prev_q, clk_sync_q[SYNC_STAGES-1]);
        if (clr) begin
            base_s = {CNT_W{1'b0}};
        end else begin
            base_s = cnt_q;
        end
        if (event_s) begin
            if (dir_sync_q[SYNC_STAGES-1]) begin
                cnt_d = base_s + CNT_W'(1'b1);
            end else begin
                cnt_d = base_s - CNT_W'(1'b1);
            end
            dir_d = dir_sync_q[SYNC_STAGES-1];
        end else begin
            cnt_d = base_s;
            dir_d = dir_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            clk_sync_q <= {SYNC_STAGES{1'b0}};
            dir_sync_q <= {SYNC_STAGES{1'b0}};
            clk_prev_q <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            dir_q      <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dir_sync_q <= dir_sync_d;
            clk_prev_q <= clk_prev_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
        end
    end

    assign cnt = cnt_q;
    assign dir = dir_q;

endmodule

// File: rtl/trackball_reader.sv
// Centipede trackball bus responder: four axis counters, clear strobe,
// player/axis select and a read-data register frozen during CPU reads.
module trackball_reader
    import centipede_pkg::*;
#(
    parameter int CNT_W       = TB_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       horclk1,
    input  logic       hordir1,
    input  logic       verclk1,
    input  logic       verdir1,
    input  logic       horclk2,
    input  logic       hordir2,
    input  logic       verclk2,
    input  logic       verdir2,
    input  logic       ballselect,
    input  logic       seltri,
    input  logic       readtb_l,
    input  logic       steerclr_l,
    output logic [7:0] data_out,
    output logic       data_oe
);

    // Strobe bit order: [0] readtb_l, [1] steerclr_l, [2] ballselect, [3] seltri.
    logic [SYNC_STAGES-1:0][3:0] strb_sync_q, strb_sync_d;
    logic                        clr_prev_q, clr_prev_d;
    logic [7:0]                  data_q, data_d;
    logic [3:0]                  strb_now_s;
    logic                        clr_pulse_s;
    tb_sel_t                     sel_s;
    logic [CNT_W-1:0]            sel_cnt_s;
    logic                        sel_dir_s;
    logic [7:0]                  rd_data_s;

    logic [3:0]       ax_clk_s;
    logic [3:0]       ax_dir_in_s;
    logic [3:0]       ax_dir_s;
    logic [CNT_W-1:0] ax_cnt_s [4];

    assign ax_clk_s    = {verclk2, horclk2, verclk1, horclk1};
    assign ax_dir_in_s = {verdir2, hordir2, verdir1, hordir1};

    for (genvar g = 0; g < 4; g++) begin : g_axis
        tb_axis_counter #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_axis (
            .clk    (clk),
            .rst_l  (rst_l),
            .tb_clk (ax_clk_s[g]),
            .tb_dir (ax_dir_in_s[g]),
            .clr    (clr_pulse_s),
            .cnt    (ax_cnt_s[g]),
            .dir    (ax_dir_s[g])
        );
    end

    // Strobe sync, clear-pulse generation, select mux and read-data hold.
    always_comb begin
        strb_sync_d = {strb_sync_q[SYNC_STAGES-2:0], {seltri, ballselect, steerclr_l, readtb_l}};
        strb_now_s  = strb_sync_q[SYNC_STAGES-1];
        clr_prev_d  = strb_now_s[1];
        clr_pulse_s = clr_prev_q & ~strb_now_s[1];
        sel_s       = tb_sel_t'({strb_now_s[2], strb_now_s[3]});
        case (sel_s)
            P1_HOR: begin sel_cnt_s = ax_cnt_s[0]; sel_dir_s = ax_dir_s[0]; end
            P1_VER: begin sel_cnt_s = ax_cnt_s[1]; sel_dir_s = ax_dir_s[1]; end
            P2_HOR: begin sel_cnt_s = ax_cnt_s[2]; sel_dir_s = ax_dir_s[2]; end
            P2_VER: begin sel_cnt_s = ax_cnt_s[3]; sel_dir_s = ax_dir_s[3]; end
            default: begin sel_cnt_s = {CNT_W{1'b0}}; sel_dir_s = 1'b0; end
        endcase
        rd_data_s              = 8'h00;
        rd_data_s[CNT_W-1:0]   = sel_cnt_s;
        rd_data_s[7]           = sel_dir_s;
        if (strb_now_s[0]) begin
            data_d = rd_data_s;
        end else begin
            data_d = data_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            strb_sync_q <= '0;
            clr_prev_q  <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            strb_sync_q <= strb_sync_d;
            clr_prev_q  <= clr_prev_d;
            data_q      <= data_d;
        end
    end

    assign data_out = data_q;
    assign data_oe  = ~readtb_l;

endmodule
